fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the RV32I pipeline.
- Sits beside the execute-stage control decoder and snoops each instruction entering execute (s2).
- Keeps a shift-register scoreboard of destination registers for NSTAGE in-flight stages past execute.
- Drives per-operand bypass selects, a load-use stall, and a saturating stall counter; supports flush and pipeline hold.

Parameters:
- NSTAGE, 2: number of post-execute stages tracked and forwardable (1..7).
- LOAD_LAT, 1: load data is forwardable only from stage index > LOAD_LAT (0 <= LOAD_LAT < NSTAGE).
- SELW, $clog2(NSTAGE+1): width of the forward-select fields.
- CNTW, 32: stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instruction_s2  in  32  instruction currently in execute.
- valid_s2  in  1  instruction_s2 is a real instruction, not a bubble.
- hold  in  1  whole-pipeline freeze (e.g. memory wait); the scoreboard does not change.
- flush  in  1  redirect (taken branch/jump); squash the s2 instruction.
- fwd_sel_1  out  SELW  rs1 source: 0 = register file, k = scoreboard stage k.
- fwd_sel_2  out  SELW  rs2 source, same encoding.
- fwd_src_1  out  2  rs1 data kind at the selected stage: 00 ALU, 01 MEM, 10 PC+4; 00 when fwd_sel_1 = 0.
- fwd_src_2  out  2  rs2 data kind, same encoding.
- stall  out  1  load-use stall: hold s2 and fetch, insert a bubble.
- stall_count  out  CNTW  registered count of cycles in which stall = 1 and hold = 0.

Behaviour:
- Decode of s2:
  - rs1 is used by RTYPE, ITYPE, LOAD, STORE, BRANCH, JALR, and CSR with func3 = 001.
  - rs1 is not used by CSR with func3 = 101, LUI, AUIPC or JAL.
  - rs2 is used by RTYPE, STORE and BRANCH only.
  - rd is written by RTYPE, ITYPE, LOAD, LUI, AUIPC, JAL and JALR.
  - Kind is MEM for LOAD, PC+4 for JAL/JALR, ALU otherwise.
  - Entries with rd = x0 are stored as not-writing.
- Scoreboard:
  - NSTAGE entries, each {wr, rd[4:0], kind[1:0]}.
  - Entry 1 holds the instruction that left execute most recently.
- Forwarding (combinational):
  - For each used operand with a non-zero source register, select the lowest k whose entry has wr = 1 and a matching rd (youngest wins).
  - No match, or operand unused, gives sel = 0 and src = 00.
  - A MEM entry at k <= LOAD_LAT is still reported in sel/src, and stall is also raised.
- Stall (combinational): stall = valid_s2 & !flush & any used operand's youngest match is a MEM entry with k <= LOAD_LAT.
  - flush overrides stall.
  - A valid_s2 = 0 input never stalls.
- Update per clock:
  - hold = 1: no change to scoreboard or stall_count.
  - Else if stall or flush or !valid_s2: entry1 <= bubble (wr = 0), entry k <= entry k-1.
  - Else: entry1 <= decoded s2, entry k <= entry k-1.
  - Entry NSTAGE is discarded on shift.
- stall_count increments when stall & !hold, and saturates at all-ones with no wrap.
- Reset (rst_n low, asynchronous):
  - All entries wr = 0; stall_count = 0.
  - Outputs therefore read sel = 0, src = 00, stall = 0 while in reset and after release.
  - Reset mid-stall drops the pending stall immediately.
- Multi-cycle load latency (LOAD_LAT = 2) produces consecutive stall cycles until the load reaches stage 3.
- Scoreboard width and select widths scale with NSTAGE; no stage beyond NSTAGE is ever selected.

Test Plan:
- Back-to-back ALU dependency (defaults). Apply addi x5,x0,1 (0x00100293), then add x6,x5,x5 (0x00528333) -> fwd_sel_1 = fwd_sel_2 = 1, src = 00, stall = 0. One non-writing instruction later, a reader of x5 gets sel = 2.
- Load-use (defaults). Apply lw x7,0(x5) (0x0002A383), then add x8,x7,x0 (0x00038433):
  - Cycle 1 -> stall = 1, sel_1 = 1, src_1 = 01, stall_count = 1.
  - Next cycle, same instruction -> stall = 0, sel_1 = 2, src_1 = 01; rs2 = x0 gives sel_2 = 0.
- Youngest-wins and x0. Entry 2 = ALU write to x5, entry 1 = MEM write to x5 with NSTAGE = 3, LOAD_LAT = 0 -> a reader of x5 gets sel = 1, src = 01, stall = 0. Apply addi x0,x0,1 (0x00100013) -> no entry writes.
- JAL forwarding. Apply jal x1,8 (0x008000EF) followed by a JALR reading x1 -> sel_1 = 1, src_1 = 10.
- Flush and hold:
  - Load-use pair with flush = 1 on the consumer -> stall = 0, bubble inserted, stall_count unchanged.
  - hold = 1 for 3 cycles during a stall -> scoreboard and stall_count frozen.
- Reset/saturation:
  - Assert rst_n = 0 mid-stall -> stall drops in the same cycle and all selects = 0.
  - With CNTW = 4, force 20 stall cycles -> stall_count = 15.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand bypass selection and load-use stall detection for an RV32I pipeline
module fwd_hazard_unit #(
   parameter int NSTAGE   = 2,
   parameter int LOAD_LAT = 1,
   parameter int SELW     = $clog2(NSTAGE + 1),
   parameter int CNTW     = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     instruction_s2,
   input  logic            valid_s2,
   input  logic            hold,
   input  logic            flush,
   output logic [SELW-1:0] fwd_sel_1,
   output logic [SELW-1:0] fwd_sel_2,
   output logic [1:0]      fwd_src_1,
   output logic [1:0]      fwd_src_2,
   output logic            stall,
   output logic [CNTW-1:0] stall_count
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYS    = 7'b1110011;

   localparam logic [1:0] K_ALU = 2'b00;
   localparam logic [1:0] K_MEM = 2'b01;
   localparam logic [1:0] K_PC4 = 2'b10;

   logic [6:0] opc;
   logic [2:0] f3;
   logic [4:0] rs1, rs2, rd;
   logic       use_1, use_2, wr_d;
   logic [1:0] kind_d;
   logic       lu_1, lu_2;

   logic [NSTAGE:1] sb_wr;
   logic [4:0]      sb_rd   [1:NSTAGE];
   logic [1:0]      sb_kind [1:NSTAGE];

   assign opc = instruction_s2[6:0];
   assign f3  = instruction_s2[14:12];
   assign rs1 = instruction_s2[19:15];
   assign rs2 = instruction_s2[24:20];
   assign rd  = instruction_s2[11:7];

   // Decode which operands the execute-stage instruction reads and what it will write
   always_comb begin
      use_1  = (opc inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR}) ||
               (opc == OP_SYS && f3 == 3'b001);
      use_2  = opc inside {OP_R, OP_STORE, OP_BRANCH};
      wr_d   = (opc inside {OP_R, OP_I, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR}) && rd != 5'd0;
      kind_d = opc == OP_LOAD ? K_MEM : (opc == OP_JAL || opc == OP_JALR) ? K_PC4 : K_ALU;
   end

   // Youngest matching writer wins: scan oldest to youngest so the lowest stage overrides
   always_comb begin
      fwd_sel_1 = '0;
      fwd_sel_2 = '0;
      fwd_src_1 = K_ALU;
      fwd_src_2 = K_ALU;
      for (int k = NSTAGE; k >= 1; k--) begin
         if (use_1 && rs1 != 5'd0 && sb_wr[k] && sb_rd[k] == rs1) begin
            fwd_sel_1 = SELW'(k);
            fwd_src_1 = sb_kind[k];
         end
         if (use_2 && rs2 != 5'd0 && sb_wr[k] && sb_rd[k] == rs2) begin
            fwd_sel_2 = SELW'(k);
            fwd_src_2 = sb_kind[k];
         end
      end
   end

   assign lu_1  = fwd_src_1 == K_MEM && fwd_sel_1 <= SELW'(LOAD_LAT);
   assign lu_2  = fwd_src_2 == K_MEM && fwd_sel_2 <= SELW'(LOAD_LAT);
   assign stall = valid_s2 & ~flush & (lu_1 | lu_2);

   // Shift the scoreboard each unfrozen cycle, inserting a bubble when s2 does not advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_wr       <= '0;
         stall_count <= '0;
         for (int k = 1; k <= NSTAGE; k++) begin
            sb_rd[k]   <= '0;
            sb_kind[k] <= '0;
         end
      end else if (!hold) begin
         sb_wr[1]   <= valid_s2 & ~stall & ~flush & wr_d;
         sb_rd[1]   <= rd;
         sb_kind[1] <= kind_d;
         for (int k = 2; k <= NSTAGE; k++) begin
            sb_wr[k]   <= sb_wr[k-1];
            sb_rd[k]   <= sb_rd[k-1];
            sb_kind[k] <= sb_kind[k-1];
         end
         if (stall && !(&stall_count))
            stall_count <= stall_count + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed checks of forwarding, load-use stall, flush, hold, reset and counter saturation
module tb_fwd_hazard_unit;

   localparam logic [31:0] ADDI_X5  = 32'h00100293;
   localparam logic [31:0] ADD_X6   = 32'h00528333;
   localparam logic [31:0] LW_X7    = 32'h0002A383;
   localparam logic [31:0] LW_X5    = 32'h0002A283;
   localparam logic [31:0] LW_X7_X7 = 32'h0003A383;
   localparam logic [31:0] ADD_X8   = 32'h00038433;
   localparam logic [31:0] ADD_X9   = 32'h000404B3;
   localparam logic [31:0] ADDI_X0  = 32'h00100013;
   localparam logic [31:0] JAL_X1   = 32'h008000EF;
   localparam logic [31:0] JALR_X1  = 32'h00108067;
   localparam logic [31:0] CSRRWI   = 32'h0003D073;
   localparam logic [31:0] CSRRW    = 32'h00039073;

   logic        clk, rst_n, valid, hold, flush;
   logic [31:0] instr;

   logic [1:0]  a_sel1, a_sel2, a_src1, a_src2, b_sel1, b_sel2, b_src1, b_src2;
   logic [1:0]  c_sel1, c_sel2, c_src1, c_src2;
   logic        a_stall, b_stall, c_stall;
   logic [31:0] a_cnt, b_cnt;
   logic [3:0]  c_cnt;

   int total = 0;
   int passed = 0;

   fwd_hazard_unit u_a (
      .clk(clk), .rst_n(rst_n), .instruction_s2(instr), .valid_s2(valid), .hold(hold), .flush(flush),
      .fwd_sel_1(a_sel1), .fwd_sel_2(a_sel2), .fwd_src_1(a_src1), .fwd_src_2(a_src2),
      .stall(a_stall), .stall_count(a_cnt)
   );

   fwd_hazard_unit #(.NSTAGE(3), .LOAD_LAT(0)) u_b (
      .clk(clk), .rst_n(rst_n), .instruction_s2(instr), .valid_s2(valid), .hold(hold), .flush(flush),
      .fwd_sel_1(b_sel1), .fwd_sel_2(b_sel2), .fwd_src_1(b_src1), .fwd_src_2(b_src2),
      .stall(b_stall), .stall_count(b_cnt)
   );

   fwd_hazard_unit #(.NSTAGE(3), .LOAD_LAT(2), .CNTW(4)) u_c (
      .clk(clk), .rst_n(rst_n), .instruction_s2(instr), .valid_s2(valid), .hold(hold), .flush(flush),
      .fwd_sel_1(c_sel1), .fwd_sel_2(c_sel2), .fwd_src_1(c_src1), .fwd_src_2(c_src2),
      .stall(c_stall), .stall_count(c_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] i, input logic v);
      instr = i;
      valid = v;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      valid = 1'b0;
      hold  = 1'b0;
      flush = 1'b0;
      instr = '0;
      cyc();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      do_reset();
      chk("rst_sel1", 32'(a_sel1), 0);
      chk("rst_sel2", 32'(a_sel2), 0);
      chk("rst_src1", 32'(a_src1), 0);
      chk("rst_stall", 32'(a_stall), 0);
      chk("rst_cnt", a_cnt, 0);
      chk("rst_cnt_c", 32'(c_cnt), 0);

      drive(ADDI_X5, 1'b1); cyc();
      drive(ADD_X6, 1'b1);
      chk("alu_sel1", 32'(a_sel1), 1);
      chk("alu_sel2", 32'(a_sel2), 1);
      chk("alu_src1", 32'(a_src1), 0);
      chk("alu_stall", 32'(a_stall), 0);
      drive(ADD_X6, 1'b0); cyc();
      drive(ADD_X6, 1'b1);
      chk("alu2_sel1", 32'(a_sel1), 2);
      chk("alu2_sel2", 32'(a_sel2), 2);

      do_reset();
      drive(LW_X7, 1'b1); cyc();
      drive(CSRRWI, 1'b1);
      chk("csri_stall", 32'(a_stall), 0);
      chk("csri_sel1", 32'(a_sel1), 0);
      drive(CSRRW, 1'b1);
      chk("csr_stall", 32'(a_stall), 1);
      chk("csr_sel1", 32'(a_sel1), 1);
      drive(ADD_X8, 1'b0);
      chk("nv_stall", 32'(a_stall), 0);
      drive(ADD_X8, 1'b1);
      chk("lu_stall", 32'(a_stall), 1);
      chk("lu_sel1", 32'(a_sel1), 1);
      chk("lu_src1", 32'(a_src1), 1);
      chk("lu_sel2", 32'(a_sel2), 0);
      chk("lu_stall_c", 32'(c_stall), 1);
      cyc();
      chk("lu_cnt", a_cnt, 1);
      chk("lu2_stall", 32'(a_stall), 0);
      chk("lu2_sel1", 32'(a_sel1), 2);
      chk("lu2_src1", 32'(a_src1), 1);
      chk("lu2_sel2", 32'(a_sel2), 0);
      chk("lu2_cnt_c", 32'(c_cnt), 1);
      chk("lu2_stall_c", 32'(c_stall), 1);
      chk("lu2_sel1_c", 32'(c_sel1), 2);
      cyc();
      chk("lu3_cnt", a_cnt, 1);
      chk("lu3_sel1", 32'(a_sel1), 0);
      chk("lu3_cnt_c", 32'(c_cnt), 2);
      chk("lu3_stall_c", 32'(c_stall), 0);
      chk("lu3_sel1_c", 32'(c_sel1), 3);
      chk("lu3_src1_c", 32'(c_src1), 1);

      do_reset();
      drive(ADDI_X5, 1'b1); cyc();
      drive(LW_X5, 1'b1); cyc();
      drive(ADD_X6, 1'b1);
      chk("yw_sel1_b", 32'(b_sel1), 1);
      chk("yw_src1_b", 32'(b_src1), 1);
      chk("yw_stall_b", 32'(b_stall), 0);
      chk("yw_stall_a", 32'(a_stall), 1);
      cyc();
      drive(ADDI_X0, 1'b1); cyc();
      drive(ADD_X6, 1'b1);
      chk("yw3_sel1_b", 32'(b_sel1), 3);
      chk("yw3_sel2_b", 32'(b_sel2), 3);
      chk("yw3_src1_b", 32'(b_src1), 1);

      do_reset();
      drive(JAL_X1, 1'b1); cyc();
      drive(JALR_X1, 1'b1);
      chk("jal_sel1", 32'(a_sel1), 1);
      chk("jal_src1", 32'(a_src1), 2);
      chk("jal_sel2", 32'(a_sel2), 0);
      chk("jal_stall", 32'(a_stall), 0);

      do_reset();
      drive(LW_X7, 1'b1); cyc();
      flush = 1'b1;
      drive(ADD_X8, 1'b1);
      chk("fl_stall", 32'(a_stall), 0);
      cyc();
      flush = 1'b0;
      chk("fl_cnt", a_cnt, 0);
      drive(ADD_X9, 1'b1);
      chk("fl_bubble_sel1", 32'(a_sel1), 0);
      drive(ADD_X8, 1'b1);
      chk("fl_shift_sel1", 32'(a_sel1), 2);
      chk("fl_shift_stall", 32'(a_stall), 0);

      do_reset();
      drive(LW_X7, 1'b1); cyc();
      drive(ADD_X8, 1'b1);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("hold_stall", 32'(a_stall), 1);
         chk("hold_sel1", 32'(a_sel1), 1);
         chk("hold_cnt", a_cnt, 0);
      end
      hold = 1'b0;
      cyc();
      chk("unhold_cnt", a_cnt, 1);
      chk("unhold_stall", 32'(a_stall), 0);
      chk("unhold_sel1", 32'(a_sel1), 2);

      do_reset();
      drive(LW_X7, 1'b1); cyc();
      drive(ADD_X8, 1'b1); cyc();
      chk("mid_stall_c", 32'(c_stall), 1);
      chk("mid_cnt_c", 32'(c_cnt), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_stall_c", 32'(c_stall), 0);
      chk("ar_sel1_c", 32'(c_sel1), 0);
      chk("ar_src1_c", 32'(c_src1), 0);
      chk("ar_cnt_c", 32'(c_cnt), 0);
      chk("ar_sel1_a", 32'(a_sel1), 0);

      do_reset();
      drive(LW_X7_X7, 1'b1);
      repeat (21) cyc();
      chk("sat_pre_c", 32'(c_cnt), 14);
      repeat (20) cyc();
      chk("sat_c", 32'(c_cnt), 15);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
